// File: rtl/resq_request_arbiter_if.sv
// Request/output bundle for the N-channel resource request arbiter.
// Request sources drive the Req_* inputs and Out_Ready. The arbiter returns
// Req_Grant and the registered output slot.
interface resq_request_arbiter_if #(
  parameter int N_CH   = 4,
  parameter int PRIO_W = 2,
  parameter int ZONE_W = 8
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [N_CH-1:0]        Req_Valid;
  logic [N_CH-1:0]        Req_Boost;
  logic [N_CH*PRIO_W-1:0] Req_Priority;
  logic [N_CH*ZONE_W-1:0] Req_Zone;
  logic [N_CH-1:0]        Req_Grant;
  logic                   Out_Ready;
  logic                   Out_Valid;
  logic [CH_W-1:0]        Out_Chan;
  logic                   Out_Boost;
  logic                   Out_Promoted;
  logic [PRIO_W-1:0]      Out_Priority;
  logic [ZONE_W-1:0]      Out_Zone;

  modport master (
    output Req_Valid, Req_Boost, Req_Priority, Req_Zone, Out_Ready,
    input  Req_Grant, Out_Valid, Out_Chan, Out_Boost, Out_Promoted,
           Out_Priority, Out_Zone
  );

  modport slave (
    input  Req_Valid, Req_Boost, Req_Priority, Req_Zone, Out_Ready,
    output Req_Grant, Out_Valid, Out_Chan, Out_Boost, Out_Promoted,
           Out_Priority, Out_Zone
  );
endinterface

// File: rtl/resq_request_arbiter.sv
// N-channel request arbiter: selects by effective boost, then priority, then
// tie-break. Age counters promote starved channels, and the winner is held
// in a registered valid/ready output slot.
module resq_request_arbiter #(
  parameter int N_CH     = 4,
  parameter int PRIO_W   = 2,
  parameter int ZONE_W   = 8,
  parameter int AGE_W    = 4,
  parameter int AGE_MAX  = 8,
  parameter int TIE_MODE = 0
) (
  input  logic clk,
  input  logic rst_n,
  resq_request_arbiter_if.slave bus
);
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int KEY_W = PRIO_W + 1;

  logic [AGE_W-1:0]  age [N_CH];
  logic [CH_W-1:0]   rr_ptr;
  logic [N_CH-1:0]   aged;
  logic [N_CH-1:0]   eff_boost;
  logic [N_CH-1:0]   grant;
  logic              load;
  logic              win_found;
  logic [CH_W-1:0]   win_idx;
  logic [KEY_W-1:0]  win_key;
  logic [KEY_W-1:0]  cand_key;
  int                scan_idx;

  logic              out_valid;
  logic [CH_W-1:0]   out_chan;
  logic              out_boost;
  logic              out_promoted;
  logic [PRIO_W-1:0] out_prio;
  logic [ZONE_W-1:0] out_zone;

  always_comb begin
    aged = '0;
    for (int i = 0; i < N_CH; i++) begin
      aged[i] = (AGE_MAX != 0) && (age[i] >= AGE_W'(AGE_MAX));
    end
    eff_boost = bus.Req_Boost | aged;
  end

  // Scan starts at rr_ptr in round-robin mode, at 0 otherwise. Only a
  // strictly better key displaces the current pick, so the first tied
  // channel in scan order wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_key   = '0;
    cand_key  = '0;
    scan_idx  = 0;
    for (int k = 0; k < N_CH; k++) begin
      scan_idx = (TIE_MODE != 0) ? int'(rr_ptr) + k : k;
      if (scan_idx >= N_CH) scan_idx = scan_idx - N_CH;
      cand_key = {eff_boost[scan_idx], bus.Req_Priority[scan_idx*PRIO_W +: PRIO_W]};
      if (bus.Req_Valid[scan_idx] && (!win_found || cand_key > win_key)) begin
        win_found = 1'b1;
        win_idx   = CH_W'(scan_idx);
        win_key   = cand_key;
      end
    end
  end

  assign load = rst_n && (bus.Req_Valid != '0) && (!out_valid || bus.Out_Ready);

  always_comb begin
    grant = '0;
    if (load) grant[win_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_chan     <= '0;
      out_boost    <= 1'b0;
      out_promoted <= 1'b0;
      out_prio     <= '0;
      out_zone     <= '0;
      rr_ptr       <= '0;
      for (int i = 0; i < N_CH; i++) age[i] <= '0;
    end else begin
      if (load) begin
        out_valid    <= 1'b1;
        out_chan     <= win_idx;
        out_boost    <= bus.Req_Boost[win_idx];
        out_promoted <= aged[win_idx] & ~bus.Req_Boost[win_idx];
        out_prio     <= bus.Req_Priority[win_idx*PRIO_W +: PRIO_W];
        out_zone     <= bus.Req_Zone[win_idx*ZONE_W +: ZONE_W];
        if (TIE_MODE != 0) begin
          rr_ptr <= (int'(win_idx) == N_CH - 1) ? '0 : win_idx + 1'b1;
        end
      end else if (out_valid && bus.Out_Ready) begin
        out_valid <= 1'b0;
      end
      // Losers age only when a transfer actually happens; backpressure freezes them.
      for (int i = 0; i < N_CH; i++) begin
        if (!bus.Req_Valid[i] || grant[i]) begin
          age[i] <= '0;
        end else if (load && (age[i] != '1)) begin
          age[i] <= age[i] + 1'b1;
        end
      end
    end
  end

  assign bus.Req_Grant    = grant;
  assign bus.Out_Valid    = out_valid;
  assign bus.Out_Chan     = out_chan;
  assign bus.Out_Boost    = out_boost;
  assign bus.Out_Promoted = out_promoted;
  assign bus.Out_Priority = out_prio;
  assign bus.Out_Zone     = out_zone;
endmodule
